inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction fetch stage for the 17-bit single-issue datapath. Holds the program counter, reads instruction memory, and registers the fetched word into an instruction register. The instruction register drives the combinational decoder directly. The decoder's branch controls (BS, PS) and the datapath zero flag come back into this block to redirect the PC; the wrong-path word is squashed as a NOP bubble.

## Interface
Parameters:
- PC_W, 8, program counter and instruction-memory address width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- stall  input  1  hold all fetch state this cycle.
- BS  input  2  branch select from the decoder: 00 increment, 01 conditional relative, 10 jump to register, 11 unconditional relative.
- PS  input  1  branch polarity from the decoder: 0 = branch on Z, 1 = branch on not-Z.
- Z  input  1  zero flag of the instruction currently in the IR.
- jump_addr  input  PC_W  register-A value, used when BS=10.
- imem_addr  output  PC_W  equals pc (combinational from the PC register).
- imem_rdata  input  17  instruction word; asynchronous read of imem_addr.
- Instruction_out  output  17  instruction register; feeds decoder Instruction_in.
- ir_pc  output  PC_W  address the IR word was fetched from.
- ir_valid  output  1  IR holds a real instruction; 0 means it holds a NOP bubble.
- redirect  output  1  combinational; a taken branch is being applied at the next edge.

## Operation
- State: pc, IR, ir_pc, ir_valid.
- Taken condition, evaluated only when ir_valid=1:
  - BS=00: not taken.
  - BS=01: taken when Z XOR PS = 1.
  - BS=10: taken.
  - BS=11: taken.
- Target address:
  - BS=10: jump_addr.
  - BS=01 and BS=11: ir_pc + sign-extend(Instruction_out[8:0]).
  - The sum is truncated to PC_W bits, so it wraps modulo 2^PC_W. If PC_W < 9, the offset is truncated to PC_W bits before the add.
- redirect = ir_valid & taken & ~stall.
- Per rising edge, in priority order:
  1. stall=1: pc, IR, ir_pc and ir_valid all hold. A pending branch stays in the IR and resolves on the first non-stalled edge.
  2. redirect=1: pc <= target; IR <= 17'h0 (NOP); ir_valid <= 0; ir_pc holds.
  3. Otherwise: IR <= imem_rdata; ir_pc <= pc; ir_valid <= 1; pc <= pc + 1, wrapping from all-ones to 0.
- Bubbles: when ir_valid=0, BS/PS/Z are ignored, so the NOP opcode (0) cannot trigger a branch.
- Opcodes are not inspected here; all branch behaviour comes from the BS/PS/Z inputs.

## Timing
- Reset (asynchronous, rst_n=0): pc=RESET_PC, Instruction_out=0, ir_pc=0, ir_valid=0, redirect=0, imem_addr=RESET_PC.
- Reset release: the first edge with rst_n=1 loads mem[RESET_PC] into the IR with ir_valid=1. That word reaches the decoder one cycle after release.
- Fetch latency: one cycle from imem_addr presentation to Instruction_out.
- Taken branch in the IR at edge k:
  - After edge k: the IR holds a bubble and pc = target.
  - After edge k+1: the IR holds mem[target].
  - Penalty is exactly one bubble cycle.
- Not-taken branch: no bubble.
- Back-to-back branches cannot occur, because a taken branch is always followed by a bubble.
- rst_n asserted mid-operation, including during stall or redirect: immediate return to reset values. No partial update survives.

## Test plan
- Reset and sequential fetch: PC_W=8, mem[i]=i. Release reset -> IR shows 0,1,2,… on successive cycles, with ir_valid=1 from the first edge. Preset pc to 8'hFE -> fetches FE, FF, then 00.
- BZ taken: IR=BZ at ir_pc=0x10, offset 9'h1F0 (-16), BS=01, PS=0, Z=1 -> redirect=1; the next cycle is a bubble (IR=0, ir_valid=0); the following IR is mem[0x00].
- BZ not taken, then BNZ: BZ with BS=01, PS=0, Z=0 -> no bubble, pc continues +1. Then BNZ with BS=01, PS=1, Z=0, offset +5 at ir_pc=0x20 -> next real IR is mem[0x25].
- Register jump and bubble immunity: BS=10, jump_addr=0xA7 -> IR = mem[0xA7] after one bubble. Driving BS=11 during that bubble has no effect.
- Stall over a branch: a taken JMP (BS=11) sits in the IR while stall=1 for 3 cycles -> pc, IR and ir_valid are constant and redirect=0 throughout. On the first unstalled edge the redirect occurs with the same target.
- Mid-operation reset: assert rst_n=0 asynchronously in the same cycle as a redirect -> outputs return to reset values immediately, with no clock edge required. After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction fetch stage: program counter, instruction-memory addressing and the
// instruction register that feeds the decoder. Branch controls coming back from
// the decoder (BS/PS) and the zero flag redirect the PC; the wrong-path word is
// replaced by a NOP bubble so a taken branch costs exactly one cycle.
module inst_fetch #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic [1:0]      BS,
    input  logic            PS,
    input  logic            Z,
    input  logic [PC_W-1:0] jump_addr,
    output logic [PC_W-1:0] imem_addr,
    input  logic [16:0]     imem_rdata,
    output logic [16:0]     Instruction_out,
    output logic [PC_W-1:0] ir_pc,
    output logic            ir_valid,
    output logic            redirect
);

    // Branch-select encodings driven by the decoder.
    localparam logic [1:0] BS_INC  = 2'b00;
    localparam logic [1:0] BS_COND = 2'b01;
    localparam logic [1:0] BS_JREG = 2'b10;
    localparam logic [1:0] BS_JREL = 2'b11;

    logic [PC_W-1:0] pc_q, pc_d;
    logic [16:0]     ir_q, ir_d;
    logic [PC_W-1:0] ir_pc_q, ir_pc_d;
    logic            ir_valid_q, ir_valid_d;

    logic            taken;
    logic [PC_W-1:0] offset;
    logic [PC_W-1:0] target;

    // Relative offset is the signed 9-bit field of the IR word, fitted to the PC width.
    // Narrow PCs simply keep the low bits, which gives the same result modulo 2^PC_W.
    generate
        if (PC_W > 9) begin : g_off_sext
            assign offset = {{(PC_W-9){ir_q[8]}}, ir_q[8:0]};
        end else if (PC_W == 9) begin : g_off_exact
            assign offset = ir_q[8:0];
        end else begin : g_off_trunc
            assign offset = ir_q[PC_W-1:0];
        end
    endgenerate

    // Decide whether the instruction in the IR is a taken branch.
    always_comb begin
        taken = 1'b0;
        case (BS)
            BS_INC:  taken = 1'b0;
            BS_COND: taken = Z ^ PS;
            BS_JREG: taken = 1'b1;
            BS_JREL: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

    // Register jumps take the A operand; relative branches are based on the IR's own address.
    assign target = (BS == BS_JREG) ? jump_addr : (ir_pc_q + offset);

    // A bubble never branches, and a stalled branch waits for the first free edge.
    assign redirect = ir_valid_q & taken & ~stall;

    // Next-state selection: stall holds everything, redirect inserts a bubble, else fetch.
    always_comb begin
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;
        if (stall) begin
            pc_d       = pc_q;
        end else if (redirect) begin
            pc_d       = target;
            ir_d       = 17'h0;
            ir_valid_d = 1'b0;
        end else begin
            ir_d       = imem_rdata;
            ir_pc_d    = pc_q;
            ir_valid_d = 1'b1;
            pc_d       = pc_q + PC_W'(1);
        end
    end

    // Fetch state registers; reset acts immediately, without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            ir_q       <= 17'h0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
        end
    end

    assign imem_addr       = pc_q;
    assign Instruction_out = ir_q;
    assign ir_pc           = ir_pc_q;
    assign ir_valid        = ir_valid_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed branch scenarios followed by random decoder
// behaviour, all compared against a cycle-level reference model of the fetch rules.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic [1:0]  BS;
    logic        PS;
    logic        Z;
    logic [7:0]  jump_addr;
    logic [7:0]  imem_addr;
    logic [16:0] imem_rdata;
    logic [16:0] Instruction_out;
    logic [7:0]  ir_pc;
    logic        ir_valid;
    logic        redirect;

    logic [16:0] mem [256];

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          m_pc;
    logic [16:0] m_ir;
    int          m_irpc;
    bit          m_valid;

    always #5 clk = ~clk;

    assign imem_rdata = mem[imem_addr];

    inst_fetch #(
        .PC_W     (8),
        .RESET_PC (8'h00)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .BS              (BS),
        .PS              (PS),
        .Z               (Z),
        .jump_addr       (jump_addr),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .Instruction_out (Instruction_out),
        .ir_pc           (ir_pc),
        .ir_valid        (ir_valid),
        .redirect        (redirect)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc    = 0;
        m_ir    = 17'h0;
        m_irpc  = 0;
        m_valid = 1'b0;
    endtask

    task automatic chk_state(input string tag);
        chk({tag, ".ir"},       32'(Instruction_out), 32'(m_ir));
        chk({tag, ".ir_pc"},    32'(ir_pc),           32'(m_irpc));
        chk({tag, ".ir_valid"}, 32'(ir_valid),        32'(m_valid));
        chk({tag, ".pc"},       32'(imem_addr),       32'(m_pc));
    endtask

    // One clock of decoder behaviour: drive controls, check redirect, clock, check state.
    task automatic step(input int bs, input int ps, input int z, input int jmp, input int st,
                        input string tag);
        bit tk;
        int off;
        int tgt;
        bit exp_redir;
        BS        = 2'(bs);
        PS        = 1'(ps);
        Z         = 1'(z);
        jump_addr = 8'(jmp);
        stall     = 1'(st);
        #1;
        tk = (bs == 2) || (bs == 3) || (bs == 1 && (z != ps));
        exp_redir = m_valid && tk && (st == 0);
        off = int'(m_ir[8:0]);
        if (off >= 256) off = off - 512;
        tgt = (bs == 2) ? jmp : (((m_irpc + off) % 256) + 256) % 256;
        chk({tag, ".redirect"}, 32'(redirect), 32'(exp_redir));
        @(posedge clk);
        if (st != 0) begin
            // everything holds
        end else if (exp_redir) begin
            m_pc    = tgt;
            m_ir    = 17'h0;
            m_valid = 1'b0;
        end else begin
            m_ir    = mem[m_pc];
            m_irpc  = m_pc;
            m_valid = 1'b1;
            m_pc    = (m_pc + 1) % 256;
        end
        #1;
        chk_state(tag);
        $display("step %-10s bs=%0d ps=%0d z=%0d st=%0d -> pc=%02h ir=%05h ir_pc=%02h v=%0d",
                 tag, bs, ps, z, st, imem_addr, Instruction_out, ir_pc, ir_valid);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 17'($urandom);
        mem[8'h10][8:0] = 9'h1F0;   // BZ back by 16
        mem[8'h20][8:0] = 9'h005;   // BNZ forward by 5

        rst_n = 1'b0; stall = 1'b0; BS = 2'b00; PS = 1'b0; Z = 1'b0; jump_addr = 8'h00;
        model_reset();
        #3;
        chk_state("reset");
        chk("reset.redirect", 32'(redirect), 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;

        // Sequential fetch from RESET_PC
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, "seq");
        chk("seq.ir_pc_const", 32'(ir_pc), 32'd5);

        // Wrap through the top of the address space
        step(2, 0, 0, 8'hFE, 0, "jmp_fe");
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, "wrap");
        chk("wrap.ir_pc_const", 32'(ir_pc), 32'h01);

        // BZ taken at 0x10, offset -16 -> 0x00
        step(2, 0, 0, 8'h10, 0, "to_10");
        step(0, 0, 0, 0, 0, "fill_10");
        step(1, 0, 1, 0, 0, "bz_taken");
        chk("bz.bubble", 32'(ir_valid), 32'd0);
        chk("bz.target", 32'(imem_addr), 32'h00);
        step(0, 0, 0, 0, 0, "bz_land");

        // BZ not taken, then BNZ at 0x20 with offset +5
        step(1, 0, 0, 0, 0, "bz_nt");
        step(2, 0, 0, 8'h20, 0, "to_20");
        step(0, 0, 0, 0, 0, "fill_20");
        step(1, 1, 0, 0, 0, "bnz_taken");
        step(0, 0, 0, 0, 0, "bnz_land");
        chk("bnz.ir_pc_const", 32'(ir_pc), 32'h25);

        // Register jump, and a relative jump driven during the bubble is ignored
        step(2, 0, 0, 8'hA7, 0, "jreg");
        step(3, 0, 0, 0, 0, "bub_imm");
        chk("jreg.land_const", 32'(ir_pc), 32'hA7);

        // Taken JMP held under stall for three cycles, then resolves
        for (int i = 0; i < 3; i++) step(3, 0, 0, 0, 1, "stall");
        step(3, 0, 0, 0, 0, "stall_rel");
        step(0, 0, 0, 0, 0, "stall_land");

        // Asynchronous reset in the same cycle as a redirect
        BS = 2'b11; stall = 1'b0;
        #1;
        chk("mid.redirect_pre", 32'(redirect), 32'(m_valid));
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk_state("mid_rst");
        chk("mid_rst.redirect", 32'(redirect), 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, "restart");

        // Random decoder behaviour
        for (int i = 0; i < 400; i++) begin
            step(int'($urandom_range(3, 0)), int'($urandom_range(1, 0)),
                 int'($urandom_range(1, 0)), int'($urandom_range(255, 0)),
                 ($urandom_range(4, 0) == 0) ? 1 : 0, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
